inst_mem_sync: RTL and testbench
================================

Name: inst_mem_sync

Overview:
Parametrised, synchronous-read instruction memory for the RISC-V fetch stage; replaces the fixed 128-byte combinational ROM. Byte-addressed, little-endian, 32-bit words, one-cycle read latency with a valid/stall handshake. Has a byte-enabled program-load write port and a post-reset clear sequencer. Flags misaligned and out-of-range fetches instead of returning undefined data.

Parameters:
ADDR_W, 32, width of fetch and load byte addresses
DEPTH_WORDS, 256, number of 32-bit words (power of two, >= 4)
INIT_CLEAR, 1, 1 = after reset, sweep every word to NOP_INST before accepting fetches; 0 = skip the sweep
NOP_INST, 32'h00000013, value driven on inst_o when idle, faulted or in reset (ADDI x0,x0,0)

Ports:
clk      in   1        rising-edge clock
rst      in   1        synchronous, active-high reset
req_i    in   1        fetch request
addr_i   in   ADDR_W   fetch byte address
stall_i  in   1        downstream stall; hold the current output
ready_o  out  1        block accepts fetches (state RUN)
inst_o   out  32       fetched instruction, {B[a+3],B[a+2],B[a+1],B[a]}
valid_o  out  1        inst_o/err_o valid this cycle
err_o    out  1        fetch fault (misaligned or out of range)
we_i     in   1        program-load write strobe
waddr_i  in   ADDR_W   load byte address (word-aligned; bits [1:0] ignored)
wdata_i  in   32       load data
wbe_i    in   4        byte enables, bit n -> byte lane n
wack_o   out  1        write committed (registered, one cycle after the accepted we_i)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. Reset value of every output: ready_o=0, valid_o=0, err_o=0, inst_o=NOP_INST, wack_o=0. Memory contents are not reset.
- FSM states: CLEAR, RUN.
- rst -> CLEAR if INIT_CLEAR=1, otherwise -> RUN.
- CLEAR: a word counter runs 0..DEPTH_WORDS-1 and writes NOP_INST to one word per cycle. ready_o=0. req_i and we_i are ignored, and wack_o stays 0. After the last word, go to RUN on the next edge. CLEAR therefore lasts exactly DEPTH_WORDS cycles.
- RUN: ready_o=1.
- Fetch is accepted when req_i && ready_o && !stall_i. On the next edge: valid_o=1 and inst_o=mem[addr_i>>2].
- Fault conditions: addr_i[1:0]!=0, or addr_i >= 4*DEPTH_WORDS. On a fault, the next cycle gives valid_o=1, err_o=1, inst_o=NOP_INST.
- No accepted fetch and no stall: next cycle valid_o=0, err_o=0, inst_o=NOP_INST.
- stall_i=1: inst_o, valid_o and err_o hold their values. A new req_i is not accepted; the requester must hold it.
- Write is accepted when we_i && state==RUN. Only lanes with wbe_i[n]=1 are updated.
- Write out of range (waddr_i >= 4*DEPTH_WORDS): the write is dropped, but wack_o still pulses so the loader never hangs.
- wack_o=1 for exactly one cycle after each accepted we_i.
- Same-cycle fetch and write to the same word: read-first. The fetch returns the old data, and the new data is visible to the next fetch.
- Write while stall_i=1: performed. The held inst_o does not change.
- rst asserted mid-CLEAR or mid-fetch: restart from the reset state next edge. Any pending output is discarded (valid_o=0).
- Index arithmetic: word index = addr_i[log2(DEPTH_WORDS)+1:2]. The range check uses the full ADDR_W address, so high bits never alias.

Decomposition:
- Shared package/define file holds: NOP_INST, the fsm state encoding (ST_CLEAR, ST_RUN), InstBus width (32) and the byte-lane count (4).
- One natural sub-module: inst_mem_bank. It is a DEPTH_WORDS x 32 single-clock array with 4 byte-write enables, one write port and one registered read-first read port, written so that synthesis infers block RAM.
- The top holds the FSM, the clear counter, fault detection, the stall hold register and the write mux (clear sequencer vs load port).

Test Plan:
- Reset with INIT_CLEAR=1, DEPTH_WORDS=16: ready_o=0 for exactly 16 cycles, then 1. A fetch from 0x20 returns 0x00000013 with valid_o=1, err_o=0.
- Load 0x002081B3 at 0x4 with wbe_i=4'hF: wack_o pulses for 1 cycle. A fetch at 0x4 gives inst_o=0x002081B3 one cycle later. A fetch at 0x6 gives err_o=1, inst_o=0x00000013.
- Partial write of 0xAABBCCDD with wbe_i=4'b0101 over 0x11223344: the readback is 0x11BB33DD.
- Fetch at 4*DEPTH_WORDS (0x40 with DEPTH_WORDS=16) -> err_o=1, valid_o=1. A write to 0x40 -> wack_o=1 and no memory change; a fetch at 0x0 stays unchanged.
- Fetch 0x8 (holding 0x00000013) with a same-cycle write of 0x12345678 to 0x8: returns 0x00000013. The next fetch of 0x8 returns 0x12345678.
- stall_i raised after a fetch of 0x4 for 3 cycles while req_i changes addr_i: inst_o and valid_o stay constant. rst pulsed mid-CLEAR: the counter restarts and ready_o stays 0 for a full DEPTH_WORDS more cycles.

Source files
------------

// File: rtl/inst_mem_sync_pkg.sv
// rtl/inst_mem_sync_pkg.sv - shared constants and FSM encoding for the instruction memory
package inst_mem_sync_pkg;

  localparam int INST_W = 32;
  localparam int LANES  = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/inst_mem_sync_if.sv
// rtl/inst_mem_sync_if.sv - fetch and program-load bus of the instruction memory
interface inst_mem_sync_if #(
  parameter int ADDR_W = 32
);
  import inst_mem_sync_pkg::*;

  logic              req_i;
  logic [ADDR_W-1:0] addr_i;
  logic              stall_i;
  logic              ready_o;
  logic [INST_W-1:0] inst_o;
  logic              valid_o;
  logic              err_o;
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [INST_W-1:0] wdata_i;
  logic [LANES-1:0]  wbe_i;
  logic              wack_o;

  modport master (
    output req_i, addr_i, stall_i, we_i, waddr_i, wdata_i, wbe_i,
    input  ready_o, inst_o, valid_o, err_o, wack_o
  );

  modport slave (
    input  req_i, addr_i, stall_i, we_i, waddr_i, wdata_i, wbe_i,
    output ready_o, inst_o, valid_o, err_o, wack_o
  );

endinterface

// File: rtl/inst_mem_bank.sv
// rtl/inst_mem_bank.sv - byte-enabled word array with a registered read-first read port
module inst_mem_bank
  import inst_mem_sync_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LANES-1:0]  wbe,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH_WORDS];

  // Read and write share one edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    if (we) begin
      for (int n = 0; n < LANES; n++) begin
        if (wbe[n]) begin
          mem[waddr][8*n +: 8] <= wdata[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/inst_mem_sync.sv
// rtl/inst_mem_sync.sv - synchronous instruction memory with clear sequencer and fault flags
module inst_mem_sync
  import inst_mem_sync_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int INIT_CLEAR  = 1,
  parameter logic [INST_W-1:0] NOP_INST = inst_mem_sync_pkg::NOP_INST
) (
  input  logic           clk,
  input  logic           rst,
  inst_mem_sync_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, err_q, wack_q;
  logic              ready;
  logic              fetch_go, fetch_fault, wr_go, wr_in_range;
  logic              bank_we;
  logic [LANES-1:0]  bank_wbe;
  logic [IDX_W-1:0]  bank_waddr;
  logic [INST_W-1:0] bank_wdata, bank_rdata;

  assign ready = (state_q == ST_RUN);

  // Range checks use the full address so high bits can never alias onto low words.
  assign fetch_fault = (bus.addr_i[1:0] != 2'b00) || ({1'b0, bus.addr_i} >= LIMIT);
  assign fetch_go    = bus.req_i && ready && !bus.stall_i;
  assign wr_in_range = ({1'b0, bus.waddr_i} < LIMIT);
  assign wr_go       = bus.we_i && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Clear sequencer owns the write port until RUN; then the load port does.
  always_comb begin
    bank_we    = 1'b0;
    bank_wbe   = '1;
    bank_waddr = cnt_q;
    bank_wdata = NOP_INST;
    if (state_q == ST_CLEAR) begin
      bank_we = 1'b1;
    end else begin
      bank_we    = wr_go && wr_in_range;
      bank_wbe   = bus.wbe_i;
      bank_waddr = bus.waddr_i[IDX_W+1:2];
      bank_wdata = bus.wdata_i;
    end
  end

  inst_mem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .wbe   (bank_wbe),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (fetch_go && !fetch_fault),
    .raddr (bus.addr_i[IDX_W+1:2]),
    .rdata (bank_rdata)
  );

  // While stalled, the flags hold and the bank read port is idle, so inst_o holds too.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wack_q  <= 1'b0;
    end else begin
      wack_q <= wr_go;
      if (!bus.stall_i) begin
        valid_q <= fetch_go;
        err_q   <= fetch_go && fetch_fault;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;
  assign bus.wack_o  = wack_q;
  assign bus.inst_o  = (valid_q && !err_q) ? bank_rdata : NOP_INST;

endmodule

// File: tb/tb_inst_mem_sync.sv
// tb/tb_inst_mem_sync.sv - directed scoreboard bench for inst_mem_sync
module tb_inst_mem_sync;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] i;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cycles;
  exp_t sb[$];

  inst_mem_sync_if #(.ADDR_W(32)) bus ();

  inst_mem_sync #(
    .ADDR_W      (32),
    .DEPTH_WORDS (DEPTH),
    .INIT_CLEAR  (1),
    .NOP_INST    (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic e, input logic [31:0] i);
    exp_t x;
    x.v = v;
    x.e = e;
    x.i = i;
    sb.push_back(x);
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, bus.valid_o}, {31'd0, x.v});
      chk({tag, "_err"},   {31'd0, bus.err_o},   {31'd0, x.e});
      chk({tag, "_inst"},  bus.inst_o,           x.i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic e, input logic [31:0] i);
    bus.req_i  = 1'b1;
    bus.addr_i = a;
    push(1'b1, e, i);
    tick();
    bus.req_i = 1'b0;
    check_out(tag);
  endtask

  task automatic write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.we_i    = 1'b1;
    bus.waddr_i = a;
    bus.wdata_i = d;
    bus.wbe_i   = be;
    tick();
    bus.we_i = 1'b0;
    chk({tag, "_wack1"}, {31'd0, bus.wack_o}, 32'd1);
    tick();
    chk({tag, "_wack0"}, {31'd0, bus.wack_o}, 32'd0);
  endtask

  task automatic count_clear(input string tag);
    cycles = 0;
    while (!bus.ready_o && cycles < 100) begin
      cycles++;
      tick();
    end
    chk(tag, cycles, DEPTH);
  endtask

  initial begin
    bus.req_i   = 1'b0;
    bus.addr_i  = '0;
    bus.stall_i = 1'b0;
    bus.we_i    = 1'b0;
    bus.waddr_i = '0;
    bus.wdata_i = '0;
    bus.wbe_i   = '0;

    tick();
    tick();
    chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    chk("rst_wack",  {31'd0, bus.wack_o},  32'd0);
    push(1'b0, 1'b0, NOP);
    check_out("rst_out");

    rst = 1'b0;
    count_clear("clear_len");

    fetch("f20", 32'h20, 1'b0, NOP);

    write("w4", 32'h4, 32'h002081B3, 4'hF);
    fetch("f4", 32'h4, 1'b0, 32'h002081B3);
    fetch("f6_mis", 32'h6, 1'b1, NOP);

    write("wc_full", 32'hC, 32'h11223344, 4'hF);
    write("wc_part", 32'hC, 32'hAABBCCDD, 4'b0101);
    fetch("fc_part", 32'hC, 1'b0, 32'h11BB33DD);

    fetch("f40_oor", 32'h40, 1'b1, NOP);
    fetch("f_hi_oor", 32'h8000_0000, 1'b1, NOP);
    write("w40_oor", 32'h40, 32'hDEADBEEF, 4'hF);
    fetch("f0_alias", 32'h0, 1'b0, NOP);

    // Same-cycle fetch and write to word 2.
    bus.we_i    = 1'b1;
    bus.waddr_i = 32'h8;
    bus.wdata_i = 32'h12345678;
    bus.wbe_i   = 4'hF;
    fetch("f8_rdfirst", 32'h8, 1'b0, NOP);
    bus.we_i = 1'b0;
    chk("w8_wack", {31'd0, bus.wack_o}, 32'd1);
    fetch("f8_new", 32'h8, 1'b0, 32'h12345678);

    // Stall hold with a changing request and a write landing underneath.
    fetch("f4_pre_stall", 32'h4, 1'b0, 32'h002081B3);
    bus.stall_i = 1'b1;
    bus.req_i   = 1'b1;
    bus.addr_i  = 32'h8;
    bus.we_i    = 1'b1;
    bus.waddr_i = 32'h4;
    bus.wdata_i = 32'hCAFEF00D;
    bus.wbe_i   = 4'hF;
    for (int k = 0; k < 3; k++) begin
      push(1'b1, 1'b0, 32'h002081B3);
      tick();
      bus.we_i   = 1'b0;
      bus.addr_i = bus.addr_i + 32'h4;
      check_out($sformatf("stall%0d", k));
    end
    bus.stall_i = 1'b0;
    bus.req_i   = 1'b0;
    push(1'b0, 1'b0, NOP);
    tick();
    check_out("idle");
    fetch("f4_after_stall", 32'h4, 1'b0, 32'hCAFEF00D);

    // Reset during a fetch discards the pending result.
    bus.req_i  = 1'b1;
    bus.addr_i = 32'h4;
    rst = 1'b1;
    push(1'b0, 1'b0, NOP);
    tick();
    bus.req_i = 1'b0;
    check_out("rst_mid_fetch");
    chk("rst_mid_fetch_ready", {31'd0, bus.ready_o}, 32'd0);

    // Reset in the middle of the clear sweep restarts the count.
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_clear_ready", {31'd0, bus.ready_o}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_clear("clear_restart_len");
    fetch("f4_cleared", 32'h4, 1'b0, NOP);
    fetch("f8_cleared", 32'h8, 1'b0, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
